// File: rtl/ifm_rdport.sv
// ifm_rdport: turns the CR-DMA address stream into SRAM reads and returns the
// read words, with their first/last tags, through a small registered FIFO.
// Optional build macro: IFM_RDPORT_PAD_EN -- the top address 2**AW-1 becomes a
// padding address that returns zeros without touching the SRAM.
module ifm_rdport #(
    parameter int DW = 64,
    parameter int AW = 11,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ifm_addr,
    input  logic          ifm_addr_first,
    input  logic          ifm_addr_last,
    input  logic          ifm_addr_valid,
    output logic          ifm_addr_ready,
    output logic          sram_ce,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_rdata,
    output logic [DW-1:0] crdma_m_data,
    output logic          crdma_m_first,
    output logic          crdma_m_last,
    output logic          crdma_m_valid,
    input  logic          crdma_m_ready,
    output logic          busy
);

    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    // One spare bit so occ + inflight cannot wrap in the credit compare.
    localparam int OW = $clog2(FD + 1) + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } ent_t;

    ent_t          fifo_mem [FD];
    ent_t          head;
    logic [PW-1:0] wptr, rptr;
    logic [OW-1:0] occ;
    logic          rd_vld, rd_pad, rd_first, rd_last;
    logic          acc, pad, push, pop, busy_q, busy_set, busy_clr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef IFM_RDPORT_PAD_EN
    assign pad = (ifm_addr == {AW{1'b1}});
`else
    assign pad = 1'b0;
`endif

    // A read issued last cycle already owns a FIFO slot; a same-cycle pop
    // is deliberately not credited so ready never depends on crdma_m_ready.
    assign ifm_addr_ready = !rst && ((occ + OW'(rd_vld)) < OW'(FD));
    assign acc            = ifm_addr_valid && ifm_addr_ready;
    assign sram_ce        = acc && !pad;
    assign sram_addr      = ifm_addr;

    assign push           = rd_vld;
    assign head           = fifo_mem[rptr];
    assign crdma_m_valid  = (occ != '0);
    assign pop            = crdma_m_valid && crdma_m_ready;

    // Outputs are forced to zero whenever nothing is presented, which also
    // covers reset since occ is cleared asynchronously.
    assign crdma_m_data   = crdma_m_valid ? head.data  : '0;
    assign crdma_m_first  = crdma_m_valid ? head.first : 1'b0;
    assign crdma_m_last   = crdma_m_valid ? head.last  : 1'b0;

    assign busy_set       = acc && ifm_addr_first;
    assign busy_clr       = pop && head.last;
    assign busy           = busy_q || busy_set;

    // Read pipeline: tags travel one cycle alongside the SRAM access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld   <= 1'b0;
            rd_pad   <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_vld   <= acc;
            rd_pad   <= pad;
            rd_first <= ifm_addr_first;
            rd_last  <= ifm_addr_last;
        end
    end

    // FIFO storage: written the cycle rdata is valid; padding pushes zeros.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= '{data: rd_pad ? '0 : sram_rdata,
                                first: rd_first, last: rd_last};
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves occ unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Burst tracker: set on an accepted first address, cleared by the popped
    // last word; a new first in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           busy_q <= 1'b0;
        else if (busy_set) busy_q <= 1'b1;
        else if (busy_clr) busy_q <= 1'b0;
    end

endmodule

// File: tb/tb_ifm_rdport.sv
// tb_ifm_rdport: directed phases with random data/backpressure, checked by a
// transaction-level scoreboard (queue of expected words) and an SRAM model.
module tb_ifm_rdport;

    localparam int DW = 64;
    localparam int AW = 11;
    localparam int FD = 4;
`ifdef IFM_RDPORT_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk, rst;
    logic [AW-1:0] ifm_addr;
    logic          ifm_addr_first, ifm_addr_last, ifm_addr_valid, ifm_addr_ready;
    logic          sram_ce;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata;
    logic [DW-1:0] crdma_m_data;
    logic          crdma_m_first, crdma_m_last, crdma_m_valid, crdma_m_ready;
    logic          busy;

    ifm_rdport #(.DW(DW), .AW(AW), .FD(FD)) dut (
        .clk(clk), .rst(rst),
        .ifm_addr(ifm_addr), .ifm_addr_first(ifm_addr_first),
        .ifm_addr_last(ifm_addr_last), .ifm_addr_valid(ifm_addr_valid),
        .ifm_addr_ready(ifm_addr_ready),
        .sram_ce(sram_ce), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .crdma_m_data(crdma_m_data), .crdma_m_first(crdma_m_first),
        .crdma_m_last(crdma_m_last), .crdma_m_valid(crdma_m_valid),
        .crdma_m_ready(crdma_m_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: rdata valid one cycle after ce.
    logic [DW-1:0] smem [2**AW];
    always @(posedge clk) if (sram_ce) sram_rdata <= smem[sram_addr];

    typedef struct { logic [DW-1:0] d; logic f; logic l; } exp_t;
    exp_t q[$];

    int pass_cnt = 0, tot_cnt = 0;
    bit busy_m = 0, hold_v = 0;
    exp_t hold_e;
    bit s_ready, s_ce, s_valid, s_acc, s_busy;
    bit rdy_mode = 0;
    int cyc_n = 0, vcnt = 0, vfirst = -1, vlast = -1, rlow = 0, busy_cnt = 0, pcnt = 0, max_out = 0;
    logic [AW-1:0] b_addr;
    int b_idx = 0, b_len = 0;
    bit b_rand = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample at negedge, check against the scoreboard, advance.
    task automatic cyc();
        bit acc, pop, pad;
        exp_t e;
        if (rdy_mode) crdma_m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        s_ready = ifm_addr_ready; s_ce = sram_ce; s_valid = crdma_m_valid;
        s_acc = ifm_addr_valid && ifm_addr_ready; s_busy = busy;
        if (rst) begin
            chk("rst_ready", ifm_addr_ready, 0);
            chk("rst_ce", sram_ce, 0);
            chk("rst_valid", crdma_m_valid, 0);
            chk("rst_first", crdma_m_first, 0);
            chk("rst_last", crdma_m_last, 0);
            chk("rst_data", crdma_m_data, 0);
            chk("rst_busy", busy, 0);
            q.delete(); busy_m = 0; hold_v = 0;
        end else begin
            // Words accepted but not yet returned = occupancy + in-flight read.
            chk("addr_ready", ifm_addr_ready, (q.size() < FD));
            acc = s_acc;
            pad = PAD && (ifm_addr == {AW{1'b1}});
            chk("sram_ce", sram_ce, acc && !pad);
            if (acc && !pad) chk("sram_addr", sram_addr, ifm_addr);
            if (hold_v) begin
                chk("hold_valid", crdma_m_valid, 1);
                chk("hold_data", crdma_m_data, hold_e.d);
                chk("hold_fl", {crdma_m_first, crdma_m_last}, {hold_e.f, hold_e.l});
            end
            chk("busy", busy, busy_m || (acc && ifm_addr_first));
            if (busy) busy_cnt++;
            pop = crdma_m_valid && crdma_m_ready;
            if (pop) begin
                pcnt++;
                chk("pop_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("out_data", crdma_m_data, e.d);
                    chk("out_first", crdma_m_first, e.f);
                    chk("out_last", crdma_m_last, e.l);
                end
            end
            if (acc) begin
                e.d = pad ? '0 : smem[ifm_addr];
                e.f = ifm_addr_first; e.l = ifm_addr_last;
                q.push_back(e);
            end
            if (acc && ifm_addr_first) busy_m = 1;
            else if (pop && crdma_m_last) busy_m = 0;
            hold_v = crdma_m_valid && !crdma_m_ready;
            hold_e.d = crdma_m_data; hold_e.f = crdma_m_first; hold_e.l = crdma_m_last;
            if (q.size() > max_out) max_out = q.size();
            if (crdma_m_valid) begin
                vcnt++;
                if (vfirst < 0) vfirst = cyc_n;
                vlast = cyc_n;
            end
            if (!ifm_addr_ready) rlow++;
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input int len, input bit rnd);
        b_addr = base; b_idx = 0; b_len = len; b_rand = rnd;
    endtask

    task automatic drive_step();
        ifm_addr_valid = (b_idx < b_len);
        ifm_addr       = b_addr;
        ifm_addr_first = (b_idx == 0);
        ifm_addr_last  = (b_idx == b_len - 1);
        cyc();
        if (s_acc) begin
            b_idx++;
            b_addr = b_rand ? AW'($urandom) : b_addr + 1'b1;
        end
        ifm_addr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && q.size() != 0; k++) cyc();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic clr_stats();
        vcnt = 0; vfirst = -1; vlast = -1; rlow = 0; busy_cnt = 0; pcnt = 0;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) smem[i] = {$urandom, $urandom};
        rst = 1'b1; ifm_addr = '0; ifm_addr_first = 0; ifm_addr_last = 0;
        ifm_addr_valid = 0; crdma_m_ready = 1'b1;
        #1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rdy_after_rst", s_ready, 1);

        // Single word at 0x005.
        clr_stats();
        ifm_addr = 11'h005; ifm_addr_first = 1; ifm_addr_last = 1; ifm_addr_valid = 1;
        cyc();
        chk("sw_acc", s_acc, 1);
        chk("sw_ce", s_ce, 1);
        ifm_addr_valid = 0;
        cyc();
        chk("sw_lat1_valid", s_valid, 0);
        cyc();
        chk("sw_lat2_valid", s_valid, 1);
        repeat (3) cyc();
        chk("sw_busy_cycles", busy_cnt, 3);
        chk("sw_empty", q.size(), 0);

        // 16-word stream with ready held high.
        clr_stats();
        start_burst(11'h100, 16, 0);
        for (int k = 0; k < 200 && b_idx < b_len; k++) drive_step();
        drain();
        chk("st_accepted", b_idx, 16);
        chk("st_valid_cnt", vcnt, 16);
        chk("st_contiguous", vlast - vfirst + 1, 16);
        chk("st_ready_low", rlow, 0);

        // Backpressure for 10 cycles mid-burst.
        crdma_m_ready = 1'b0;
        start_burst(11'h200, 16, 0);
        repeat (10) drive_step();
        chk("bp_buffered", b_idx, FD);
        chk("bp_ready_low", s_ready, 0);
        crdma_m_ready = 1'b1;
        for (int k = 0; k < 300 && b_idx < b_len; k++) drive_step();
        chk("bp_accepted", b_idx, 16);
        drain();

        // 200 random words with 50% downstream ready.
        max_out = 0;
        rdy_mode = 1;
        start_burst(AW'($urandom), 200, 1);
        for (int k = 0; k < 5000 && b_idx < b_len; k++) drive_step();
        chk("rnd_accepted", b_idx, 200);
        rdy_mode = 0; crdma_m_ready = 1'b1;
        drain();
        chk("rnd_max_outstanding", (max_out <= FD), 1);

        // Reset after 5 of 16 words, address still offered during reset.
        start_burst(11'h300, 16, 0);
        for (int k = 0; k < 100 && b_idx < 5; k++) drive_step();
        rst = 1'b1;
        ifm_addr_valid = 1'b1; ifm_addr = 11'h305; ifm_addr_first = 0; ifm_addr_last = 0;
        cyc(); cyc();
        ifm_addr_valid = 1'b0;
        rst = 1'b0;
        cyc();
        chk("rdy_post_rst", s_ready, 1);
        clr_stats();
        start_burst(11'h340, 16, 0);
        for (int k = 0; k < 200 && b_idx < b_len; k++) drive_step();
        drain();
        chk("post_rst_pops", pcnt, 16);

        // Top address: padding or a real read depending on build.
        ifm_addr = {AW{1'b1}}; ifm_addr_first = 1; ifm_addr_last = 1; ifm_addr_valid = 1;
        cyc();
        chk("pad_acc", s_acc, 1);
        chk("pad_ce", s_ce, !PAD);
        ifm_addr_valid = 0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/ifm_rdport.md
IFM_RDPORT -- requirements
Module: ifm_rdport

Interface
REQ-001 SHALL have parameter DW, default 64, data word width in bits.
REQ-002 SHALL have parameter AW, default 11, address width; the buffer holds 2**AW words.
REQ-003 SHALL have parameter FD, default 4, return-FIFO depth; legal values are 4 or greater.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports ifm_addr / ifm_addr_first / ifm_addr_last / ifm_addr_valid, inputs of AW/1/1/1 bits: address stream from the CR-DMA.
REQ-007 SHALL have port ifm_addr_ready, output, 1 bit: address accept.
REQ-008 SHALL have ports sram_ce (output, 1 bit), sram_addr (output, AW bits) and sram_rdata (input, DW bits): synchronous single-port read, rdata valid exactly 1 cycle after ce.
REQ-009 SHALL have ports crdma_m_data / crdma_m_first / crdma_m_last / crdma_m_valid, outputs of DW/1/1/1 bits, plus crdma_m_ready, input, 1 bit: data stream returned to the CR-DMA.
REQ-010 SHALL have port busy, output, 1 bit: high from the accepted first address until the matching last data word is accepted.

Function
REQ-011 SHALL accept an address when ifm_addr_valid && ifm_addr_ready; only an accepted address causes a read.
REQ-012 SHALL drive ifm_addr_ready = (occ + inflight) < FD, where occ is the registered FIFO occupancy and inflight is 1 if a read was issued in the previous cycle; a pop in the same cycle is not credited.
REQ-013 SHALL drive sram_ce = ifm_addr_valid && ifm_addr_ready combinationally, with sram_addr = ifm_addr.
REQ-014 SHALL delay first/last by one cycle alongside the read and push {sram_rdata, first, last} into the FIFO in the cycle after ce.
REQ-015 SHALL present FIFO head data registered, so crdma_m_valid rises 2 cycles after the address handshake when the FIFO was empty.
REQ-016 SHALL sustain one word per cycle when crdma_m_ready is held high.
REQ-017 SHALL pop the FIFO on crdma_m_valid && crdma_m_ready.
REQ-018 SHALL hold crdma_m_data, crdma_m_first and crdma_m_last stable while crdma_m_valid is high and crdma_m_ready is low.
REQ-019 SHALL never overflow the FIFO; simultaneous push and pop leaves occ unchanged.
REQ-020 SHALL wrap the FIFO read and write pointers modulo FD.
REQ-021 SHALL set busy on an accepted address with first = 1 and clear it on the popped word with last = 1; if both events occur in one cycle, set takes priority.
REQ-022 SHALL treat an address with first = 1 and last = 1 as a one-word burst: busy pulses for the duration of that word.
REQ-023 SHALL pass first/last through unchanged and perform no burst-protocol checking.

Reset
REQ-024 SHALL, on rst assertion at any time including mid-burst, clear occ, the pointers, inflight and busy; any in-flight read is discarded.
REQ-025 SHALL hold the outputs at these values during reset: ifm_addr_ready = 0, sram_ce = 0, crdma_m_valid = 0, crdma_m_first = 0, crdma_m_last = 0, crdma_m_data = 0, busy = 0.
REQ-026 SHALL assert ifm_addr_ready in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when IFM_RDPORT_PAD_EN is defined, treat address 2**AW-1 as padding: no sram_ce is issued, the pushed data is all zeros, and latency and ordering are identical to a real read.
REQ-028 SHALL, when IFM_RDPORT_PAD_EN is undefined, read address 2**AW-1 from the SRAM like any other address.

Verification
REQ-029 Single word: addr 0x005, first = 1, last = 1, ready held high -> sram_ce in the handshake cycle, crdma_m_valid 2 cycles later with the SRAM word at 0x005, first = 1, last = 1; busy high for 3 cycles.
REQ-030 Streaming: 16-word burst at addresses 0x100..0x10F, ready held high -> 16 consecutive valid cycles, data in order, first on word 0 and last on word 15, ifm_addr_ready never low.
REQ-031 Backpressure: crdma_m_ready low for 10 cycles during a burst -> exactly FD words are buffered, ifm_addr_ready is 0, the head stays stable, and no word is lost or duplicated after release.
REQ-032 Full/empty boundary: random ready pattern at 50% over 200 words -> occ never exceeds FD, output order matches input order, and the pointers wrap correctly.
REQ-033 Reset mid-burst: rst asserted after 5 of 16 words -> all outputs take their reset values immediately; a fresh burst after reset completes correctly.
REQ-034 Padding: with IFM_RDPORT_PAD_EN defined, addr 0x7FF -> no sram_ce and data 0; with it undefined -> sram_ce issued and the SRAM word at 0x7FF is returned.
